// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: ready/valid FIFO built around an external dual-port BRAM.
// Port A writes, port B reads with one cycle of registered latency; a
// 2-entry skid buffer on the output hides that latency for 1 word/cycle.
module bram_fifo_ctrl #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA-1:0]   enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA-1:0]   deq_data,
    output logic [ADDR+1:0]   count,
    output logic              bram_a_wr,
    output logic [ADDR-1:0]   bram_a_addr,
    output logic [DATA-1:0]   bram_a_din,
    output logic              bram_b_wr,
    output logic [ADDR-1:0]   bram_b_addr,
    output logic [DATA-1:0]   bram_b_din,
    input  logic [DATA-1:0]   bram_b_dout
);

    logic [ADDR:0]     wr_ptr;
    logic [ADDR:0]     rd_ptr;
    logic [ADDR:0]     bram_cnt;
    logic              rd_pending;
    logic [1:0]        buf_cnt;
    logic [DATA-1:0]   buf0;
    logic [DATA-1:0]   buf1;
    logic              out_of_reset;

    logic              enq_fire;
    logic              deq_fire;
    logic              rd_issue;
    logic [2:0]        occ_next;
    logic [1:0]        buf_left;

    // Words written but not yet issued for read; never exceeds 2**ADDR,
    // so its MSB alone flags the full condition.
    assign bram_cnt  = wr_ptr - rd_ptr;
    assign enq_ready = out_of_reset & ~bram_cnt[ADDR];
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_valid = (buf_cnt != 2'd0);
    assign deq_fire  = deq_valid & deq_ready;
    assign deq_data  = buf0;

    // Occupancy of the skid buffer once this cycle's push/pop settle.
    assign occ_next  = {1'b0, buf_cnt} + {2'b00, rd_pending} - {2'b00, deq_fire};
    assign buf_left  = buf_cnt - {1'b0, deq_fire};
    assign rd_issue  = (bram_cnt != '0) && (occ_next <= 3'd1);

    assign count = (ADDR+2)'(bram_cnt) + (ADDR+2)'(rd_pending) + (ADDR+2)'(buf_cnt);

    assign bram_a_wr   = enq_fire;
    assign bram_a_addr = wr_ptr[ADDR-1:0];
    assign bram_a_din  = enq_data;
    assign bram_b_wr   = 1'b0;
    assign bram_b_addr = rd_ptr[ADDR-1:0];
    assign bram_b_din  = '0;

    // Pointer, read-pending and ready-enable state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_pending   <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            rd_pending <= rd_issue;
        end
    end

    // Skid buffer: pop shifts entry 1 forward, then the returning BRAM word
    // lands in the first free slot (the later assignment wins on overlap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0    <= '0;
            buf1    <= '0;
            buf_cnt <= 2'd0;
        end else begin
            if (deq_fire) buf0 <= buf1;
            if (rd_pending) begin
                if (buf_left == 2'd0) buf0 <= bram_b_dout;
                else                  buf1 <= bram_b_dout;
            end
            buf_cnt <= occ_next[1:0];
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Testbench for bram_fifo_ctrl with a behavioural BRAM and a queue-based
// reference model of the FIFO contents and occupancy.
module tb_bram_fifo_ctrl;

    localparam int DATA  = 8;
    localparam int ADDR  = 4;
    localparam int DEPTH = 2**ADDR;

    logic              clk;
    logic              rst_n;
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA-1:0]   enq_data;
    logic              deq_valid;
    logic              deq_ready;
    logic [DATA-1:0]   deq_data;
    logic [ADDR+1:0]   count;
    logic              bram_a_wr;
    logic [ADDR-1:0]   bram_a_addr;
    logic [DATA-1:0]   bram_a_din;
    logic              bram_b_wr;
    logic [ADDR-1:0]   bram_b_addr;
    logic [DATA-1:0]   bram_b_din;
    logic [DATA-1:0]   bram_b_dout;

    int checks   = 0;
    int failures = 0;

    bram_fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .count(count),
        .bram_a_wr(bram_a_wr), .bram_a_addr(bram_a_addr), .bram_a_din(bram_a_din),
        .bram_b_wr(bram_b_wr), .bram_b_addr(bram_b_addr), .bram_b_din(bram_b_din),
        .bram_b_dout(bram_b_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port BRAM: synchronous write on A, registered read on B.
    logic [DATA-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bram_a_wr) mem[bram_a_addr] <= bram_a_din;
        bram_b_dout <= mem[bram_b_addr];
    end

    // Reference model: all held words in order, plus where they sit.
    logic [DATA-1:0] q[$];
    int  m_bram, m_pend, m_buf;
    bit  m_rdy;
    int  obs_fires;
    int  max_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_bram = 0; m_pend = 0; m_buf = 0; m_rdy = 0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cycle(input bit ev, input logic [DATA-1:0] d, input bit dr);
        bit exp_rdy, efire, dfire, issue;
        enq_valid = ev; enq_data = d; deq_ready = dr;
        @(negedge clk);
        exp_rdy = m_rdy && (m_bram < DEPTH);
        efire   = ev && exp_rdy;
        dfire   = dr && (m_buf > 0);
        issue   = (m_bram > 0) && (m_buf + m_pend - int'(dfire) <= 1);
        chk("enq_ready", 32'(enq_ready), 32'(exp_rdy));
        chk("deq_valid", 32'(deq_valid), 32'(m_buf > 0));
        if (m_buf > 0) chk("deq_data", 32'(deq_data), 32'(q[0]));
        chk("count", 32'(count), 32'(q.size()));
        chk("bram_a_wr", 32'(bram_a_wr), 32'(efire));
        chk("bram_b_wr", 32'(bram_b_wr), 32'd0);
        chk("buf_cnt_le2", 32'(dut.buf_cnt <= 2'd2), 32'd1);
        if (efire) chk("bram_a_din", 32'(bram_a_din), 32'(d));
        if (efire && issue) chk("ab_addr_distinct", 32'(bram_a_addr != bram_b_addr), 32'd1);
        if (deq_valid && dr) obs_fires++;
        if (int'(count) > max_count) max_count = int'(count);
        m_buf  = m_buf + m_pend - int'(dfire);
        m_pend = int'(issue);
        m_bram = m_bram + int'(efire) - int'(issue);
        if (dfire) void'(q.pop_front());
        if (efire) q.push_back(d);
        @(posedge clk);
        #1;
        m_rdy = 1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
        obs_fires = 0; max_count = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd0);
        chk("rst_deq_data", 32'(deq_data), 32'd0);
        chk("rst_a_wr", 32'(bram_a_wr), 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);

        // First word latency: enq at cycle 0, visible at cycle 3.
        cycle(1'b1, 8'h5A, 1'b0);
        chk("fw_count_c1", 32'(count), 32'd1);
        cycle(1'b0, '0, 1'b0);
        chk("fw_valid_c2", 32'(deq_valid), 32'd0);
        cycle(1'b0, '0, 1'b0);
        chk("fw_valid_c3", 32'(deq_valid), 32'd1);
        chk("fw_data_c3", 32'(deq_data), 32'h5A);
        chk("fw_count_c3", 32'(count), 32'd1);
        cycle(1'b0, '0, 1'b1);

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(i + 8'h30), 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("mid_rst_enq_ready", 32'(enq_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);

        // Fill to full with the consumer stalled.
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 8'(i + 8'h80), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        chk("full_count", 32'(count), 32'(DEPTH + 2));
        cycle(1'b0, '0, 1'b1);
        chk("full_ready_back", 32'(enq_ready), 32'd1);
        drain(DEPTH + 6);
        chk("full_drained", 32'(count), 32'd0);

        // Sustained streaming: 100 words, one per cycle.
        obs_fires = 0;
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'(i), 1'b1);
        drain(3);
        chk("stream_throughput", 32'(obs_fires), 32'd100);

        // Random backpressure and producer gaps.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        drain(DEPTH + 6);

        // Pointer wrap through a mostly-empty FIFO.
        max_count = 0;
        for (int i = 0; i < 3 * DEPTH; i++) cycle(1'b1, 8'(i * 7 + 3), 1'($urandom_range(0, 7) != 0));
        drain(DEPTH + 6);
        chk("wrap_max_count", 32'(max_count <= DEPTH + 2), 32'd1);
        chk("wrap_empty", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
